// File: rtl/vldu_replay_ctrl_pkg.sv
// Shared types for the VLDU replay controller: FSM states, the latched command
// record and the command normalisation helper.
package vldu_replay_ctrl_pkg;

  localparam int CMD_LEN_W  = 16;
  localparam int CMD_PASS_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    SKIP,
    FLUSH
  } replay_state_e;

  typedef struct packed {
    logic [CMD_LEN_W-1:0]  len;
    logic [CMD_PASS_W-1:0] passes;
  } replay_cmd_t;

  // Zero or oversize length means a full buffer; zero passes means one pass.
  // Pass counts above the maximum are clamped so the pass counter cannot wrap.
  function automatic replay_cmd_t normalise_cmd(
    input logic [CMD_LEN_W-1:0]  len,
    input logic [CMD_PASS_W-1:0] passes,
    input int unsigned           depth,
    input int unsigned           max_passes
  );
    replay_cmd_t           c;
    logic [CMD_LEN_W-1:0]  d;
    logic [CMD_PASS_W-1:0] m;
    d = CMD_LEN_W'(depth);
    m = CMD_PASS_W'(max_passes);
    c.len    = ((len == '0) || (len > d)) ? d : len;
    c.passes = (passes == '0) ? CMD_PASS_W'(1) : ((passes > m) ? m : passes);
    return c;
  endfunction

endpackage

// File: rtl/vldu_replay_ctrl.sv
// Replays the contents of the VLSU re-readable buffer to the lanes a given
// number of times, realigning the read pointer between short passes.
module vldu_replay_ctrl
  import vldu_replay_ctrl_pkg::*;
#(
  parameter int RD_DATA_WIDTH = 32,
  parameter int DEPTH         = 8,
  parameter int MAX_PASSES    = 256,
  parameter int LenWidth      = $clog2(DEPTH + 1),
  parameter int PassWidth     = $clog2(MAX_PASSES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [LenWidth-1:0]      cmd_len_i,
  input  logic [PassWidth-1:0]     cmd_passes_i,
  input  logic                     abort_i,
  input  logic [RD_DATA_WIDTH-1:0] buf_data_i,
  input  logic                     buf_empty_i,
  input  logic                     buf_load_finished_i,
  output logic                     buf_pop_o,
  output logic                     buf_flush_o,
  output logic [RD_DATA_WIDTH-1:0] data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_elem_o,
  output logic                     last_pass_o,
  output logic                     busy_o
);

  replay_state_e        r_state;
  replay_cmd_t          r_cmd;
  logic [LenWidth-1:0]  r_elem_cnt;
  logic [PassWidth-1:0] r_pass_cnt;
  logic [LenWidth-1:0]  r_skip_cnt;
  logic                 r_load_done;

  replay_cmd_t w_cmd_norm;
  logic        w_stream;
  logic        w_skip;
  logic        w_valid;
  logic        w_stream_pop;
  logic        w_skip_pop;
  logic        w_elem_last;
  logic        w_pass_last;
  logic        w_skip_last;
  logic        w_full_len;

  assign w_cmd_norm = normalise_cmd(CMD_LEN_W'(cmd_len_i), CMD_PASS_W'(cmd_passes_i),
                                    DEPTH, MAX_PASSES);

  assign w_stream = (r_state == STREAM);
  assign w_skip   = (r_state == SKIP);

  assign w_elem_last = (CMD_LEN_W'(r_elem_cnt) == (r_cmd.len - CMD_LEN_W'(1)));
  assign w_pass_last = (CMD_PASS_W'(r_pass_cnt) == (r_cmd.passes - CMD_PASS_W'(1)));
  // Skip pops needed to bring the read pointer back round to element 0.
  assign w_skip_last = (CMD_LEN_W'(r_skip_cnt) ==
                        (CMD_LEN_W'(DEPTH) - r_cmd.len - CMD_LEN_W'(1)));
  assign w_full_len  = (r_cmd.len == CMD_LEN_W'(DEPTH));

  assign w_valid      = w_stream & ~buf_empty_i & ~abort_i;
  assign w_stream_pop = w_valid & ready_i;
  // Skipping must not overtake the writer, so wait for the full load.
  assign w_skip_pop   = w_skip & (r_load_done | buf_load_finished_i) & ~abort_i;

  assign valid_o     = w_valid;
  assign buf_pop_o   = w_stream_pop | w_skip_pop;
  assign buf_flush_o = (r_state == FLUSH);
  assign cmd_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign data_o      = w_stream ? buf_data_i : '0;
  assign last_elem_o = w_stream & w_elem_last;
  assign last_pass_o = w_stream & w_pass_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_elem_cnt  <= '0;
      r_pass_cnt  <= '0;
      r_skip_cnt  <= '0;
      r_load_done <= 1'b0;
    end else begin
      if (buf_flush_o) begin
        r_load_done <= 1'b0;
      end else if (buf_load_finished_i) begin
        r_load_done <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_cmd   <= w_cmd_norm;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (abort_i) begin
            r_state <= FLUSH;
          end else if (w_stream_pop) begin
            if (w_elem_last) begin
              r_elem_cnt <= '0;
              if (w_pass_last) begin
                r_state <= FLUSH;
              end else begin
                r_pass_cnt <= r_pass_cnt + PassWidth'(1);
                r_state    <= w_full_len ? STREAM : SKIP;
              end
            end else begin
              r_elem_cnt <= r_elem_cnt + LenWidth'(1);
            end
          end
        end
        SKIP: begin
          if (abort_i) begin
            r_state <= FLUSH;
          end else if (w_skip_pop) begin
            if (w_skip_last) begin
              r_skip_cnt <= '0;
              r_state    <= STREAM;
            end else begin
              r_skip_cnt <= r_skip_cnt + LenWidth'(1);
            end
          end
        end
        FLUSH: begin
          r_cmd      <= '0;
          r_elem_cnt <= '0;
          r_pass_cnt <= '0;
          r_skip_cnt <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vldu_replay_ctrl.sv
// Self-checking bench for vldu_replay_ctrl with a behavioural re-readable
// buffer that loads at one element per cycle or one per four cycles.
module tb_vldu_replay_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int LW    = 4;
  localparam int PW    = 9;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [LW-1:0] cmd_len_i;
  logic [PW-1:0] cmd_passes_i;
  logic          abort_i;
  logic [DW-1:0] buf_data_i;
  logic          buf_empty_i;
  logic          buf_load_finished_i;
  logic          buf_pop_o;
  logic          buf_flush_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_elem_o;
  logic          last_pass_o;
  logic          busy_o;

  vldu_replay_ctrl #(
    .RD_DATA_WIDTH(DW),
    .DEPTH        (DEPTH),
    .MAX_PASSES   (256)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cmd_valid_i        (cmd_valid_i),
    .cmd_ready_o        (cmd_ready_o),
    .cmd_len_i          (cmd_len_i),
    .cmd_passes_i       (cmd_passes_i),
    .abort_i            (abort_i),
    .buf_data_i         (buf_data_i),
    .buf_empty_i        (buf_empty_i),
    .buf_load_finished_i(buf_load_finished_i),
    .buf_pop_o          (buf_pop_o),
    .buf_flush_o        (buf_flush_o),
    .data_o             (data_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .last_elem_o        (last_elem_o),
    .last_pass_o        (last_pass_o),
    .busy_o             (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural buffer: element i holds {seed, i}; read pointer wraps at DEPTH.
  logic [3:0] m_wr_cnt;
  logic [2:0] m_rd_ptr;
  logic       m_loading;
  logic [1:0] m_tick;
  logic       m_slow;
  logic       load_go;
  logic [7:0] seed;

  assign buf_empty_i = (m_wr_cnt < 4'(DEPTH)) && ({1'b0, m_rd_ptr} >= m_wr_cnt);
  assign buf_data_i  = {16'h0, seed, 5'h0, m_rd_ptr};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr_cnt            <= '0;
      m_rd_ptr            <= '0;
      m_loading           <= 1'b0;
      m_tick              <= '0;
      buf_load_finished_i <= 1'b0;
    end else begin
      buf_load_finished_i <= 1'b0;
      if (buf_flush_o) begin
        m_wr_cnt  <= '0;
        m_rd_ptr  <= '0;
        m_loading <= 1'b0;
        m_tick    <= '0;
      end else begin
        if (buf_pop_o) m_rd_ptr <= m_rd_ptr + 3'd1;
        if (load_go) begin
          m_loading <= 1'b1;
          m_tick    <= '0;
        end else if (m_loading) begin
          if (!m_slow || m_tick == 2'd3) begin
            m_tick   <= '0;
            m_wr_cnt <= m_wr_cnt + 4'd1;
            if (m_wr_cnt == 4'd7) begin
              m_loading           <= 1'b0;
              buf_load_finished_i <= 1'b1;
            end
          end else begin
            m_tick <= m_tick + 2'd1;
          end
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    check({tag, "_busy"},      32'(busy_o),      32'd0);
    check({tag, "_valid"},     32'(valid_o),     32'd0);
    check({tag, "_pop"},       32'(buf_pop_o),   32'd0);
    check({tag, "_flush"},     32'(buf_flush_o), 32'd0);
    check({tag, "_data"},      data_o,           32'd0);
    check({tag, "_last_elem"}, 32'(last_elem_o), 32'd0);
    check({tag, "_last_pass"}, 32'(last_pass_o), 32'd0);
  endtask

  task automatic load_buffer(input logic slow, input logic [7:0] s);
    @(negedge clk);
    seed    = s;
    m_slow  = slow;
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
  endtask

  task automatic wait_loaded();
    for (int i = 0; i < 200 && m_wr_cnt != 4'd8; i++) @(negedge clk);
    check("load_complete", 32'(m_wr_cnt == 4'd8), 32'd1);
  endtask

  task automatic issue_cmd(input logic [LW-1:0] len, input logic [PW-1:0] passes);
    for (int i = 0; i < 50 && !cmd_ready_o; i++) @(negedge clk);
    check("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i  = 1'b1;
    cmd_len_i    = len;
    cmd_passes_i = passes;
    @(negedge clk);
    cmd_valid_i  = 1'b0;
  endtask

  // Drives ready/abort each cycle and checks every beat against the expected
  // element sequence; ends on the flush cycle.
  task automatic run_stream(input int exp_len, input int exp_passes, input bit stall,
                            input bit slow, input int abort_p, input int abort_e,
                            input logic [7:0] s);
    int          e = 0, p = 0, beats = 0, skips = 0, early_skips = 0, cyc = 0;
    bit          done = 0, fin_seen = 0, stalled = 0, aborted = 0;
    logic [31:0] prev_data = '0;
    logic [3:0]  pat = 4'b1001;
    fin_seen = !slow;
    while (!done && cyc < 2000) begin
      ready_i = stall ? pat[cyc % 4] : 1'b1;
      abort_i = !aborted && (p == abort_p) && (e == abort_e);
      if (abort_i) aborted = 1;
      #1;
      if (buf_load_finished_i) fin_seen = 1;
      if (abort_i) begin
        check("abort_pop",   32'(buf_pop_o), 32'd0);
        check("abort_valid", 32'(valid_o),   32'd0);
      end else if (valid_o) begin
        check("beat_data", data_o, {16'h0, s, 8'(e)});
        check("last_elem", 32'(last_elem_o), 32'(e == exp_len - 1));
        check("last_pass", 32'(last_pass_o), 32'(p == exp_passes - 1));
        check("pop_eq_ready", 32'(buf_pop_o), 32'(ready_i));
        if (stalled) check("stall_hold", data_o, prev_data);
        if (ready_i) begin
          beats++;
          stalled = 0;
          if (e == exp_len - 1) begin
            e = 0;
            p++;
          end else begin
            e++;
          end
        end else begin
          stalled   = 1;
          prev_data = data_o;
        end
      end else if (buf_pop_o) begin
        skips++;
        if (!fin_seen) early_skips++;
      end
      if (buf_flush_o) done = 1;
      @(negedge clk);
      cyc++;
    end
    abort_i = 1'b0;
    ready_i = 1'b0;
    check("flush_seen", 32'(done), 32'd1);
    if (abort_p >= 0) begin
      check("abort_beats", 32'(beats), 32'(abort_p * exp_len + abort_e));
    end else begin
      check("beat_count", 32'(beats), 32'(exp_len * exp_passes));
      check("skip_pops",  32'(skips), 32'((DEPTH - exp_len) * (exp_passes - 1)));
      check("skip_before_load_done", 32'(early_skips), 32'd0);
    end
    #1;
    check("post_flush_ready", 32'(cmd_ready_o), 32'd1);
    check("post_flush_busy",  32'(busy_o),      32'd0);
    check("single_flush",     32'(buf_flush_o), 32'd0);
    $display("txn len=%0d passes=%0d stall=%0d slow=%0d abort=%0d: beats=%0d skips=%0d cycles=%0d",
             exp_len, exp_passes, stall, slow, abort_p >= 0, beats, skips, cyc);
  endtask

  typedef struct {
    logic [LW-1:0] len;
    logic [PW-1:0] passes;
    bit            slow;
    bit            stall;
    int            exp_len;
    int            exp_passes;
    logic [7:0]    seed;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 4'd8,  passes: 9'd3, slow: 0, stall: 0, exp_len: 8, exp_passes: 3, seed: 8'h00};
    vecs[1] = '{len: 4'd5,  passes: 9'd2, slow: 0, stall: 0, exp_len: 5, exp_passes: 2, seed: 8'h11};
    vecs[2] = '{len: 4'd3,  passes: 9'd2, slow: 1, stall: 0, exp_len: 3, exp_passes: 2, seed: 8'h22};
    vecs[3] = '{len: 4'd8,  passes: 9'd2, slow: 0, stall: 1, exp_len: 8, exp_passes: 2, seed: 8'h33};
    vecs[4] = '{len: 4'd0,  passes: 9'd0, slow: 0, stall: 0, exp_len: 8, exp_passes: 1, seed: 8'h44};
    vecs[5] = '{len: 4'd12, passes: 9'd1, slow: 0, stall: 0, exp_len: 8, exp_passes: 1, seed: 8'h55};
    vecs[6] = '{len: 4'd1,  passes: 9'd3, slow: 0, stall: 1, exp_len: 1, exp_passes: 3, seed: 8'h66};

    rst_n        = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_len_i    = '0;
    cmd_passes_i = '0;
    abort_i      = 1'b0;
    ready_i      = 1'b0;
    load_go      = 1'b0;
    m_slow       = 1'b0;
    seed         = 8'h00;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      load_buffer(vecs[i].slow, vecs[i].seed);
      if (!vecs[i].slow) wait_loaded();
      issue_cmd(vecs[i].len, vecs[i].passes);
      run_stream(vecs[i].exp_len, vecs[i].exp_passes, vecs[i].stall, vecs[i].slow,
                 -1, -1, vecs[i].seed);
    end

    // Abort on the second element of the second pass, then replay from 0.
    load_buffer(1'b0, 8'h77);
    wait_loaded();
    issue_cmd(4'd8, 9'd4);
    run_stream(8, 4, 1'b0, 1'b0, 1, 1, 8'h77);
    load_buffer(1'b0, 8'h78);
    wait_loaded();
    issue_cmd(4'd8, 9'd1);
    run_stream(8, 1, 1'b0, 1'b0, -1, -1, 8'h78);

    // Reset asserted in the middle of a stream.
    load_buffer(1'b0, 8'h99);
    wait_loaded();
    issue_cmd(4'd0, 9'd0);
    ready_i = 1'b1;
    #1;
    check("pre_reset_valid", 32'(valid_o), 32'd1);
    check("pre_reset_busy",  32'(busy_o),  32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_data", data_o, {16'h0, 8'h99, 8'd3});
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn mid-stream reset applied and released");

    load_buffer(1'b0, 8'hAB);
    wait_loaded();
    issue_cmd(4'd5, 9'd2);
    run_stream(5, 2, 1'b0, 1'b0, -1, -1, 8'hAB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
